gmii_tx_framer: RTL and testbench

- Parametrised GMII transmit MAC datapath, the next generation after the bare GMII pin-level shell.
- Accepts a frame as a byte stream on a valid/ready interface and emits it on the GMII TX pins. Adds the preamble and SFD, pads to a minimum frame length, appends the IEEE 802.3 FCS, and enforces the inter-frame gap.
- Sits between the TX FIFO read side and the GMII TX pins, in the 125 MHz TX domain.

---
 rtl/mac_pkg.sv | 38 +++
 rtl/crc32_d8_reg.sv | 37 +++
 rtl/gmii_tx_framer.sv | 239 +++++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the GMII MAC datapath.
//   tx_state_t : transmit framer states
//   byte/CRC constants used by the TX framer (and a future RX checker)
//   crc32_d8   : one-byte update of a reflected CRC-32 register
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        SFD   = 3'd2,
        DATA  = 3'd3,
        PAD   = 3'd4,
        FCS   = 3'd5,
        IFG   = 3'd6,
        DRAIN = 3'd7
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    // Reflected CRC-32: bytes enter LSB first, register shifts right.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY_REFL;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8_reg.sv
// CRC-32 accumulator register, one byte per enabled cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (register -> CRC_INIT)
//   init : synchronous reload of CRC_INIT (wins over en)
//   en   : fold data into the register this cycle
//   data : byte to fold in
//   crc  : current (non-inverted) register value
module crc32_d8_reg
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_r;

    // CRC state: reload, byte update or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= CRC_INIT;
        end else if (init) begin
            crc_r <= CRC_INIT;
        end else if (en) begin
            crc_r <= crc32_d8(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, padding, FCS append, IFG.
// Ports:
//   CLK, RST                      : 125 MHz TX clock, async active-high reset
//   S_TDATA/TVALID/TLAST/TUSER    : frame byte stream in (TUSER = errored byte)
//   S_TREADY                      : byte accepted when S_TVALID & S_TREADY
//   TX_D, TX_EN, TX_ERR           : registered GMII TX pins
//   STAT_FRAME_DONE               : pulse in the first idle cycle after a good frame
//   STAT_UNDERRUN                 : pulse alongside the underrun error byte
// The output registers are loaded from the decision made in the current
// state, so the wire runs one cycle behind the state register: the SFD is on
// TX_D during the first DATA cycle, and the last FCS byte during the first IFG
// cycle.
module gmii_tx_framer
    import mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12,
    parameter int FCS_EN       = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] S_TDATA,
    input  logic       S_TVALID,
    input  logic       S_TLAST,
    input  logic       S_TUSER,
    output logic       S_TREADY,
    output logic [7:0] TX_D,
    output logic       TX_EN,
    output logic       TX_ERR,
    output logic       STAT_FRAME_DONE,
    output logic       STAT_UNDERRUN
);

    localparam logic [16:0] MIN_W    = 17'(MIN_FRAME);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    tx_state_t   state_r, state_n;
    logic [7:0]  aux_r, aux_n;          // preamble / FCS / IFG position
    logic [15:0] cnt_r, cnt_n;          // payload+pad byte count, saturating
    logic        abort_r, abort_n;      // current frame ended by underrun
    logic [7:0]  tx_d_r, tx_d_n;
    logic        tx_en_r, tx_en_n;
    logic        tx_err_r, tx_err_n;
    logic        done_r, done_n;
    logic        und_r, und_n;

    logic        crc_init_s, crc_en_s;
    logic [7:0]  crc_data_s;
    logic [31:0] crc_s;
    logic [16:0] cnt_inc_s;             // unsaturated count after this byte
    logic [15:0] cnt_sat_s;
    logic [7:0]  fcs_byte_s;

    crc32_d8_reg u_crc (
        .clk  (CLK),
        .rst  (RST),
        .init (crc_init_s),
        .en   (crc_en_s),
        .data (crc_data_s),
        .crc  (crc_s)
    );

    assign cnt_inc_s = {1'b0, cnt_r} + 17'd1;
    assign cnt_sat_s = (cnt_r == 16'hFFFF) ? cnt_r : cnt_inc_s[15:0];

    // FCS goes out inverted, least significant byte first
    always_comb begin
        case (aux_r[1:0])
            2'd0:    fcs_byte_s = ~crc_s[7:0];
            2'd1:    fcs_byte_s = ~crc_s[15:8];
            2'd2:    fcs_byte_s = ~crc_s[23:16];
            2'd3:    fcs_byte_s = ~crc_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Next-state and next-output decode
    always_comb begin
        state_n    = state_r;
        aux_n      = aux_r;
        cnt_n      = cnt_r;
        abort_n    = abort_r;
        tx_d_n     = 8'h00;
        tx_en_n    = 1'b0;
        tx_err_n   = 1'b0;
        und_n      = 1'b0;
        crc_init_s = 1'b0;
        crc_en_s   = 1'b0;
        crc_data_s = 8'h00;
        done_n     = (state_r == IFG) && (aux_r == 8'd0) && !abort_r;

        case (state_r)
            IDLE: begin
                if (S_TVALID) begin
                    tx_d_n  = PREAMBLE_BYTE;
                    tx_en_n = 1'b1;
                    aux_n   = 8'd1;
                    // this cycle already launches the first preamble byte
                    if (PREAMBLE_LEN > 1) begin
                        state_n = PRE;
                    end else begin
                        state_n = SFD;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            PRE: begin
                tx_d_n  = PREAMBLE_BYTE;
                tx_en_n = 1'b1;
                aux_n   = aux_r + 8'd1;
                if (aux_r == PRE_LAST) begin
                    state_n = SFD;
                end else begin
                    state_n = PRE;
                end
            end
            SFD: begin
                tx_d_n     = SFD_BYTE;
                tx_en_n    = 1'b1;
                crc_init_s = 1'b1;
                cnt_n      = 16'd0;
                abort_n    = 1'b0;
                state_n    = DATA;
            end
            DATA: begin
                if (S_TVALID) begin
                    tx_d_n     = S_TDATA;
                    tx_en_n    = 1'b1;
                    tx_err_n   = S_TUSER;
                    crc_en_s   = 1'b1;
                    crc_data_s = S_TDATA;
                    cnt_n      = cnt_sat_s;
                    if (S_TLAST) begin
                        aux_n = 8'd0;
                        if (cnt_inc_s < MIN_W) begin
                            state_n = PAD;
                        end else if (FCS_EN != 0) begin
                            state_n = FCS;
                        end else begin
                            state_n = IFG;
                        end
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    // underrun: poison the frame on the wire, then discard the rest
                    tx_en_n  = 1'b1;
                    tx_err_n = 1'b1;
                    und_n    = 1'b1;
                    abort_n  = 1'b1;
                    state_n  = DRAIN;
                end
            end
            PAD: begin
                tx_en_n  = 1'b1;
                crc_en_s = 1'b1;
                cnt_n    = cnt_sat_s;
                if (cnt_inc_s >= MIN_W) begin
                    aux_n = 8'd0;
                    if (FCS_EN != 0) begin
                        state_n = FCS;
                    end else begin
                        state_n = IFG;
                    end
                end else begin
                    state_n = PAD;
                end
            end
            FCS: begin
                tx_d_n  = fcs_byte_s;
                tx_en_n = 1'b1;
                if (aux_r == 8'd3) begin
                    aux_n   = 8'd0;
                    state_n = IFG;
                end else begin
                    aux_n   = aux_r + 8'd1;
                    state_n = FCS;
                end
            end
            IFG: begin
                if (aux_r == IFG_LAST) begin
                    aux_n   = 8'd0;
                    state_n = IDLE;
                end else begin
                    aux_n   = aux_r + 8'd1;
                    state_n = IFG;
                end
            end
            DRAIN: begin
                if (S_TVALID && S_TLAST) begin
                    aux_n   = 8'd0;
                    state_n = IFG;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                aux_n   = 8'd0;
            end
        endcase
    end

    // State, counters and registered GMII/status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            aux_r    <= 8'd0;
            cnt_r    <= 16'd0;
            abort_r  <= 1'b0;
            tx_d_r   <= 8'h00;
            tx_en_r  <= 1'b0;
            tx_err_r <= 1'b0;
            done_r   <= 1'b0;
            und_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            aux_r    <= aux_n;
            cnt_r    <= cnt_n;
            abort_r  <= abort_n;
            tx_d_r   <= tx_d_n;
            tx_en_r  <= tx_en_n;
            tx_err_r <= tx_err_n;
            done_r   <= done_n;
            und_r    <= und_n;
        end
    end

    assign S_TREADY        = (state_r == DATA) || (state_r == DRAIN);
    assign TX_D            = tx_d_r;
    assign TX_EN           = tx_en_r;
    assign TX_ERR          = tx_err_r;
    assign STAT_FRAME_DONE = done_r;
    assign STAT_UNDERRUN   = und_r;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench: dut_a (MIN_FRAME=0) and dut_b (defaults).
module tb_gmii_tx_framer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] s_tvalid = 2'b00, s_tlast = 2'b00, s_tuser = 2'b00;
    logic [7:0] s_tdata [2];

    logic [7:0] a_d, b_d;
    logic a_en, a_err, a_done, a_und, a_tready;
    logic b_en, b_err, b_done, b_und, b_tready;

    always #4 CLK = ~CLK;

    gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_BYTES(12), .FCS_EN(1)) dut_a (
        .CLK(CLK), .RST(RST), .S_TDATA(s_tdata[0]), .S_TVALID(s_tvalid[0]),
        .S_TLAST(s_tlast[0]), .S_TUSER(s_tuser[0]), .S_TREADY(a_tready),
        .TX_D(a_d), .TX_EN(a_en), .TX_ERR(a_err),
        .STAT_FRAME_DONE(a_done), .STAT_UNDERRUN(a_und)
    );

    gmii_tx_framer dut_b (
        .CLK(CLK), .RST(RST), .S_TDATA(s_tdata[1]), .S_TVALID(s_tvalid[1]),
        .S_TLAST(s_tlast[1]), .S_TUSER(s_tuser[1]), .S_TREADY(b_tready),
        .TX_D(b_d), .TX_EN(b_en), .TX_ERR(b_err),
        .STAT_FRAME_DONE(b_done), .STAT_UNDERRUN(b_und)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q0[$];   // {err, data} expected on the wire
    logic [8:0] exp_q1[$];
    logic [7:0] cap_q[$];    // dut_b wire bytes
    logic [7:0] pay_q[$];    // payload of the frame being sent

    int run0 = 0, last_run0 = 0, done_cnt0 = 0, und_cnt0 = 0;
    int run1 = 0, last_run1 = 0, done_cnt1 = 0, und_cnt1 = 0;
    int idle_cnt1 = 0, last_gap1 = 0, rdy_cnt1 = 0;
    logic prev_en0 = 1'b0, prev_en1 = 1'b0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endfunction

    function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // monitor for dut_a
    initial forever begin
        @(negedge CLK);
        if (a_en) begin
            run0++;
            if (exp_q0.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_byte got=%h want=none", a_d);
            end else begin
                chk("a_txbyte", {23'd0, a_err, a_d}, {23'd0, exp_q0.pop_front()});
            end
        end else if (prev_en0) begin
            last_run0 = run0;
            run0 = 0;
        end
        if (a_done) done_cnt0++;
        if (a_und) und_cnt0++;
        prev_en0 = a_en;
    end

    // monitor for dut_b
    initial forever begin
        @(negedge CLK);
        if (b_tready) rdy_cnt1++;
        if (b_en) begin
            if (!prev_en1) last_gap1 = idle_cnt1;
            run1++;
            cap_q.push_back(b_d);
            if (exp_q1.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_byte got=%h want=none", b_d);
            end else begin
                chk("b_txbyte", {23'd0, b_err, b_d}, {23'd0, exp_q1.pop_front()});
            end
        end else begin
            if (prev_en1) begin
                last_run1 = run1;
                run1 = 0;
                idle_cnt1 = 1;
            end else begin
                idle_cnt1++;
            end
        end
        if (b_done) begin
            done_cnt1++;
            chk("done_position", {30'd0, prev_en1, b_en}, 32'd2);
        end
        if (b_und) und_cnt1++;
        prev_en1 = b_en;
    end

    // expected wire image of a dut_b frame; stall_at >= 0 ends it in an underrun
    task automatic exp_frame(input int user_at, input int minf, input int stall_at);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF;
        n = pay_q.size();
        for (int i = 0; i < 7; i++) exp_q1.push_back({1'b0, 8'h55});
        exp_q1.push_back({1'b0, 8'hD5});
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                exp_q1.push_back({1'b1, 8'h00});
                return;
            end
            exp_q1.push_back({(i == user_at), pay_q[i]});
            c = crc_byte(c, pay_q[i]);
        end
        for (int i = n; i < minf; i++) begin
            exp_q1.push_back({1'b0, 8'h00});
            c = crc_byte(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q1.push_back({1'b0, c[8*i +: 8]});
    endtask

    task automatic send(input int sel, input int stall_at, input int user_at, input int stop_after);
        int n, waitc;
        logic acc;
        n = pay_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                s_tvalid[sel] = 1'b0;
                @(posedge CLK); #1;
            end
            s_tvalid[sel] = 1'b1;
            s_tdata[sel]  = pay_q[i];
            s_tlast[sel]  = (i == n - 1);
            s_tuser[sel]  = (i == user_at);
            if (i == stop_after) return;
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 400) begin
                @(negedge CLK);
                acc = (sel == 0) ? a_tready : b_tready;
                @(posedge CLK); #1;
                waitc++;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL accept_timeout got=no_ready want=ready byte=%0d", i);
                s_tvalid[sel] = 1'b0;
                return;
            end
        end
        s_tvalid[sel] = 1'b0;
        s_tlast[sel]  = 1'b0;
        s_tuser[sel]  = 1'b0;
    endtask

    task automatic wait_drain(input int sel);
        int k;
        k = 0;
        while (((sel == 0) ? exp_q0.size() : exp_q1.size()) != 0 && k < 2000) begin
            @(posedge CLK);
            k++;
        end
        chk("drain_queue", (sel == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
        repeat (20) @(posedge CLK);
        #1;
    endtask

    task automatic fill_pay(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'((i * 37 + 11) & 255));
    endtask

    initial begin
        int d0, u0, r0;
        logic [31:0] c;
        s_tdata[0] = 8'h00;
        s_tdata[1] = 8'h00;

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx_d", {24'd0, b_d}, 32'h00);
        chk("rst_tx_en", {31'd0, b_en}, 32'd0);
        chk("rst_tx_err", {31'd0, b_err}, 32'd0);
        chk("rst_tready", {31'd0, b_tready}, 32'd0);
        chk("rst_stats", {30'd0, b_done, b_und}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // "123456789", no padding: check value 0xCBF43926 -> 26 39 F4 CB
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
        for (int i = 0; i < 7; i++) exp_q0.push_back({1'b0, 8'h55});
        exp_q0.push_back({1'b0, 8'hD5});
        for (int i = 0; i < 9; i++) exp_q0.push_back({1'b0, pay_q[i]});
        exp_q0.push_back({1'b0, 8'h26});
        exp_q0.push_back({1'b0, 8'h39});
        exp_q0.push_back({1'b0, 8'hF4});
        exp_q0.push_back({1'b0, 8'hCB});
        d0 = done_cnt0;
        send(0, -1, -1, -1);
        wait_drain(0);
        chk("check9_en_run", last_run0, 32'd21);
        chk("check9_done", done_cnt0 - d0, 32'd1);
        chk("check9_no_underrun", und_cnt0, 32'd0);

        // 1-byte frame padded to 60
        pay_q.delete();
        pay_q.push_back(8'hAB);
        cap_q.delete();
        exp_frame(-1, 60, -1);
        d0 = done_cnt1;
        send(1, -1, -1, -1);
        wait_drain(1);
        chk("short_en_run", last_run1, 32'd72);
        chk("short_cap_len", cap_q.size(), 32'd72);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < cap_q.size(); i++) c = crc_byte(c, cap_q[i]);
        chk("short_residue", c, 32'hDEBB20E3);
        chk("short_done", done_cnt1 - d0, 32'd1);

        // underrun at byte 40 of 100
        fill_pay(100);
        exp_frame(-1, 60, 40);
        d0 = done_cnt1; u0 = und_cnt1; r0 = rdy_cnt1;
        send(1, 40, -1, -1);
        wait_drain(1);
        chk("und_pulse", und_cnt1 - u0, 32'd1);
        chk("und_no_done", done_cnt1 - d0, 32'd0);
        chk("und_en_run", last_run1, 32'd49);
        chk("und_ready_cycles", rdy_cnt1 - r0, 32'd101);

        // back-to-back 64-byte frames, valid held
        fill_pay(64);
        d0 = done_cnt1; r0 = rdy_cnt1;
        exp_frame(-1, 60, -1);
        send(1, -1, -1, -1);
        exp_frame(-1, 60, -1);
        send(1, -1, -1, -1);
        wait_drain(1);
        chk("b2b_gap", last_gap1, 32'd12);
        chk("b2b_ready_cycles", rdy_cnt1 - r0, 32'd128);
        chk("b2b_done", done_cnt1 - d0, 32'd2);
        chk("b2b_en_run", last_run1, 32'd76);

        // errored byte 10 of 60
        fill_pay(60);
        exp_frame(10, 60, -1);
        d0 = done_cnt1;
        send(1, -1, 10, -1);
        wait_drain(1);
        chk("tuser_en_run", last_run1, 32'd72);
        chk("tuser_done", done_cnt1 - d0, 32'd1);

        // reset mid-DATA, then a clean frame
        fill_pay(30);
        exp_frame(-1, 60, -1);
        send(1, -1, -1, 5);
        @(posedge CLK); #1;
        chk("mid_en_before", {31'd0, b_en}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_en", {31'd0, b_en}, 32'd0);
        chk("mid_rst_ready", {31'd0, b_tready}, 32'd0);
        s_tvalid[1] = 1'b0;
        s_tlast[1]  = 1'b0;
        exp_q1.delete();
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_idle", {22'd0, b_tready, b_en, b_d}, 32'd0);
        fill_pay(20);
        exp_frame(-1, 60, -1);
        d0 = done_cnt1;
        send(1, -1, -1, -1);
        wait_drain(1);
        chk("post_rst_done", done_cnt1 - d0, 32'd1);
        chk("post_rst_en_run", last_run1, 32'd72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
